// File: rtl/gmii_rx_fifo_writer.sv
// GMII receive packer feeding the write side of a clock-crossing FIFO.
// Frame-aware write gating against almost-full, error-tail marking, prefill start and statistics.
module gmii_rx_fifo_writer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PREFILL    = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    gmii_rx_en,
    input  logic                    gmii_rx_er,
    input  logic [DATA_WIDTH-1:0]   gmii_rxd,
    input  logic                    fifo_afull,
    output logic                    wrreq,
    output logic [DATA_WIDTH+1:0]   FIFO_data,
    output logic                    rd_start,
    output logic [CNT_WIDTH-1:0]    frame_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt
);

    localparam int unsigned WORD_WIDTH = DATA_WIDTH + 2;
    localparam int unsigned PRE_WIDTH  = 8;
    localparam logic [PRE_WIDTH-1:0]  PREFILL_CNT = PRE_WIDTH'(PREFILL);
    localparam logic [WORD_WIDTH-1:0] ERR_WORD    = {2'b11, DATA_WIDTH'(0)};

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_FRAME,
        ST_DROP,
        ST_ERRTAIL
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    partial;
    logic                    partial_nxt;
    logic [PRE_WIDTH-1:0]    prefill_cnt;

    logic                    wr_c;
    logic [WORD_WIDTH-1:0]   data_c;
    logic [WORD_WIDTH-1:0]   sample_c;
    logic                    frame_inc_c;
    logic                    drop_inc_c;

    assign sample_c = {gmii_rx_en, gmii_rx_er, gmii_rxd};

    // Next-state and write decision; almost-full always wins the write decision.
    always_comb begin
        state_nxt   = state;
        partial_nxt = partial;
        wr_c        = 1'b0;
        data_c      = sample_c;
        frame_inc_c = 1'b0;
        drop_inc_c  = 1'b0;
        case (state)
            ST_SYNC: begin
                if (!gmii_rx_en && !fifo_afull) begin
                    wr_c      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fifo_afull) begin
                    if (gmii_rx_en) begin
                        drop_inc_c  = 1'b1;
                        partial_nxt = 1'b0;
                        state_nxt   = ST_DROP;
                    end
                end else begin
                    wr_c = 1'b1;
                    if (gmii_rx_en) begin
                        frame_inc_c = 1'b1;
                        state_nxt   = ST_FRAME;
                    end
                end
            end
            ST_FRAME: begin
                if (!fifo_afull) begin
                    wr_c = 1'b1;
                    if (!gmii_rx_en) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (gmii_rx_en) begin
                    drop_inc_c  = 1'b1;
                    partial_nxt = 1'b1;
                    state_nxt   = ST_DROP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!gmii_rx_en) begin
                    state_nxt = partial ? ST_ERRTAIL : ST_IDLE;
                end
            end
            ST_ERRTAIL: begin
                if (!fifo_afull) begin
                    wr_c   = 1'b1;
                    data_c = ERR_WORD;
                    if (gmii_rx_en) begin
                        drop_inc_c  = 1'b1;
                        partial_nxt = 1'b0;
                        state_nxt   = ST_DROP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SYNC;
            partial <= 1'b0;
        end else begin
            state   <= state_nxt;
            partial <= partial_nxt;
        end
    end

    // Registered FIFO write port; data holds when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrreq     <= 1'b0;
            FIFO_data <= '0;
        end else begin
            wrreq <= wr_c;
            if (wr_c) begin
                FIFO_data <= data_c;
            end
        end
    end

    // rd_start rises together with the PREFILL-th write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefill_cnt <= '0;
            rd_start    <= 1'b0;
        end else if (wr_c) begin
            if (prefill_cnt != PREFILL_CNT) begin
                prefill_cnt <= prefill_cnt + PRE_WIDTH'(1);
            end
            if ((prefill_cnt + PRE_WIDTH'(1)) >= PREFILL_CNT) begin
                rd_start <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_inc_c && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
            if (drop_inc_c && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_fifo_writer.sv
// Directed self-checking bench for gmii_rx_fifo_writer (DATA_WIDTH=8, PREFILL=4, CNT_WIDTH=4).
module tb_gmii_rx_fifo_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_en = 1'b1;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        fifo_afull = 1'b0;
    logic        wrreq;
    logic [9:0]  FIFO_data;
    logic        rd_start;
    logic [3:0]  frame_cnt;
    logic [3:0]  drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    gmii_rx_fifo_writer #(
        .DATA_WIDTH (8),
        .PREFILL    (4),
        .CNT_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rx_en (gmii_rx_en),
        .gmii_rx_er (gmii_rx_er),
        .gmii_rxd   (gmii_rxd),
        .fifo_afull (fifo_afull),
        .wrreq      (wrreq),
        .FIFO_data  (FIFO_data),
        .rd_start   (rd_start),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one sample, then observe the registered result 1 ns after the edge.
    task automatic step(input logic e, input logic r, input logic [7:0] d, input logic af);
        gmii_rx_en = e;
        gmii_rx_er = r;
        gmii_rxd   = d;
        fifo_afull = af;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_seen;
        int bad;
        logic [7:0] d;
        logic       er;

        // Reset held with a frame in progress
        repeat (2) @(posedge clk);
        #1;
        check("rst_wrreq", 32'(wrreq), 32'd0);
        check("rst_data", 32'(FIFO_data), 32'h000);
        check("rst_rd_start", 32'(rd_start), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // Release mid-frame: SYNC must hold off until rx_en drops
        rst_n = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            wr_seen += int'(wrreq);
        end
        check("sync_no_write", 32'(wr_seen), 32'd0);
        step(1'b0, 1'b0, 8'h55, 1'b0);
        check("sync_exit_wrreq", 32'(wrreq), 32'd1);
        check("sync_exit_data", 32'(FIFO_data), 32'h055);
        check("sync_frame_cnt", 32'(frame_cnt), 32'd0);
        check("prefill_1", 32'(rd_start), 32'd0);

        // Prefill: rd_start rises with the 4th write
        step(1'b0, 1'b0, 8'h01, 1'b0);
        check("prefill_2", 32'(rd_start), 32'd0);
        step(1'b0, 1'b0, 8'h02, 1'b0);
        check("prefill_3", 32'(rd_start), 32'd0);
        step(1'b0, 1'b0, 8'h03, 1'b0);
        check("prefill_4_wrreq", 32'(wrreq), 32'd1);
        check("prefill_4", 32'(rd_start), 32'd1);

        // 72-cycle frame, no backpressure, rx_er passed through on one byte
        wr_seen = 0;
        bad = 0;
        for (int i = 0; i < 72; i++) begin
            d  = 8'(i * 3 + 1);
            er = (i == 30);
            step(1'b1, er, d, 1'b0);
            wr_seen += int'(wrreq);
            if (!wrreq || FIFO_data !== {1'b1, er, d}) bad++;
        end
        check("frame_words", 32'(wr_seen), 32'd72);
        check("frame_bad_words", 32'(bad), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("frame_idle_data", 32'(FIFO_data), 32'h000);
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);
        check("drop_cnt_0", 32'(drop_cnt), 32'd0);
        check("rd_start_sticky", 32'(rd_start), 32'd1);

        // afull on bytes 20..25: truncate, then one error tail word
        wr_seen = 0;
        bad = 0;
        for (int i = 0; i < 72; i++) begin
            d = 8'(i);
            step(1'b1, 1'b0, d, (i >= 20 && i <= 25));
            wr_seen += int'(wrreq);
            if (i < 20 && (!wrreq || FIFO_data !== {2'b10, d})) bad++;
        end
        check("trunc_words", 32'(wr_seen), 32'd20);
        check("trunc_bad_words", 32'(bad), 32'd0);
        step(1'b0, 1'b0, 8'hAA, 1'b0);
        check("trunc_idle_not_written", 32'(wrreq), 32'd0);
        step(1'b0, 1'b0, 8'hAA, 1'b1);
        check("errtail_waits_afull", 32'(wrreq), 32'd0);
        step(1'b0, 1'b0, 8'hAA, 1'b0);
        check("errtail_wrreq", 32'(wrreq), 32'd1);
        check("errtail_data", 32'(FIFO_data), 32'h300);
        check("trunc_drop_cnt", 32'(drop_cnt), 32'd1);
        check("trunc_frame_cnt", 32'(frame_cnt), 32'd2);
        step(1'b0, 1'b0, 8'h11, 1'b0);
        check("after_tail_idle", 32'(FIFO_data), 32'h011);

        // afull across the whole frame: nothing written, no tail
        wr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b1);
            wr_seen += int'(wrreq);
        end
        check("dropall_words", 32'(wr_seen), 32'd0);
        step(1'b0, 1'b0, 8'hAA, 1'b0);
        check("dropall_idle_skip", 32'(wrreq), 32'd0);
        step(1'b0, 1'b0, 8'h22, 1'b0);
        check("dropall_no_tail", 32'(FIFO_data), 32'h022);
        check("dropall_drop_cnt", 32'(drop_cnt), 32'd2);
        check("dropall_frame_cnt", 32'(frame_cnt), 32'd2);

        // afull coinciding with the frame end: complete frame, no drop
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        step(1'b0, 1'b0, 8'h33, 1'b1);
        check("end_afull_wrreq", 32'(wrreq), 32'd0);
        step(1'b0, 1'b0, 8'h34, 1'b0);
        check("end_afull_resume", 32'(FIFO_data), 32'h034);
        check("end_afull_frame_cnt", 32'(frame_cnt), 32'd3);
        check("end_afull_drop_cnt", 32'(drop_cnt), 32'd2);

        // Error tail slot collides with the next frame's first byte
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
        step(1'b1, 1'b0, 8'h5F, 1'b1);
        check("collide_drop_1", 32'(drop_cnt), 32'd3);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b0);
        check("collide_tail_data", 32'(FIFO_data), 32'h300);
        check("collide_drop_2", 32'(drop_cnt), 32'd4);
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            wr_seen += int'(wrreq);
        end
        step(1'b0, 1'b0, 8'h44, 1'b0);
        wr_seen += int'(wrreq);
        check("collide_dropped_words", 32'(wr_seen), 32'd0);
        step(1'b0, 1'b0, 8'h45, 1'b0);
        check("collide_recover", 32'(FIFO_data), 32'h045);
        check("collide_frame_cnt", 32'(frame_cnt), 32'd4);

        // 20 more frames saturate the 4-bit frame counter
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(f), 1'b0);
            step(1'b0, 1'b0, 8'h00, 1'b0);
        end
        check("frame_cnt_sat", 32'(frame_cnt), 32'd15);
        check("drop_cnt_stable", 32'(drop_cnt), 32'd4);

        // Async reset mid-frame, then the in-progress frame is suppressed
        step(1'b1, 1'b0, 8'h12, 1'b0);
        step(1'b1, 1'b0, 8'h13, 1'b0);
        check("pre_reset_wrreq", 32'(wrreq), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_wrreq", 32'(wrreq), 32'd0);
        check("async_rst_data", 32'(FIFO_data), 32'h000);
        check("async_rst_rd_start", 32'(rd_start), 32'd0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            wr_seen += int'(wrreq);
        end
        check("post_rst_suppressed", 32'(wr_seen), 32'd0);
        step(1'b0, 1'b0, 8'h66, 1'b0);
        check("post_rst_first_word", 32'(FIFO_data), 32'h066);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("post_rst_rd_start", 32'(rd_start), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
